hazard_ctrl_206: RTL and testbench

HAZARD_CTRL_206 -- requirements
Module: hazard_ctrl_206

---
 rtl/hazard_ctrl_206.sv | 99 +++++++++
 tb/tb_hazard_ctrl_206.sv | 119 +++++++++++
 2 files changed

// File: rtl/hazard_ctrl_206.sv
// hazard_ctrl_206: pipeline hazard controller for load-use, branch flush,
// memory-wait and multi-cycle mul/div occupancy.
// Ports: clk/rst_n (async active-low reset); rs_ID/rt_ID/uses_rt_ID describe
// the ID instruction; rd_EX/memread_EX/branch_taken_EX/md_start_EX describe EX;
// mem_req_MEM/mem_ready describe MEM. Outputs are the stall/flush controls for
// the PC and pipeline registers, md_busy, and a saturating stall_cycles count.
module hazard_ctrl_206 #(
  parameter int MD_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  rs_ID,
  input  logic [4:0]  rt_ID,
  input  logic        uses_rt_ID,
  input  logic [4:0]  rd_EX,
  input  logic        memread_EX,
  input  logic        branch_taken_EX,
  input  logic        md_start_EX,
  input  logic        mem_req_MEM,
  input  logic        mem_ready,
  output logic        pc_stall,
  output logic        if_id_stall,
  output logic        if_id_flush,
  output logic        id_ex_stall,
  output logic        id_ex_flush,
  output logic        ex_mem_flush,
  output logic        md_busy,
  output logic [15:0] stall_cycles
);
  localparam logic [1:0] RUN = 2'd0;
  localparam logic [1:0] MW  = 2'd1;
  localparam logic [1:0] MD  = 2'd2;
  // control bundle order: pc_stall, if_id_stall, if_id_flush, id_ex_stall,
  // id_ex_flush, ex_mem_flush, md_busy
  localparam logic [6:0] C_NONE = 7'b0000000;
  localparam logic [6:0] C_HOLD = 7'b1101010;
  localparam logic [6:0] C_BR   = 7'b0010100;
  localparam logic [6:0] C_LU   = 7'b1100100;
  localparam logic [6:0] C_MD   = 7'b1101011;
  logic [1:0]  state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [15:0] stall_cycles_q, stall_cycles_d;
  logic [6:0]  ctl;
  logic        load_use, mem_wait;
  assign load_use = memread_EX && (rd_EX != 5'd0) &&
                    ((rd_EX == rs_ID) || (uses_rt_ID && (rd_EX == rt_ID)));
  assign mem_wait = mem_req_MEM && !mem_ready;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ctl     = C_NONE;
    case (state_q)
      RUN: begin
        if (mem_wait) begin
          ctl     = C_HOLD;
          state_d = MW;
        end else if (branch_taken_EX) begin
          ctl = C_BR;
        end else if (md_start_EX) begin
          // entry cycle counts as the first EX cycle; exit cycle is the last
          ctl     = C_HOLD;
          cnt_d   = 8'(MD_CYCLES - 2);
          state_d = MD;
        end else if (load_use) begin
          ctl = C_LU;
        end
      end
      MW: begin
        if (mem_ready) state_d = RUN;
        else ctl = C_HOLD;
      end
      MD: begin
        if (cnt_q == 8'd0) begin
          state_d = RUN;
        end else begin
          ctl   = C_MD;
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: state_d = RUN;
    endcase
    // outputs are combinational from inputs, so reset must mask them directly
    if (!rst_n) ctl = C_NONE;
    stall_cycles_d = (ctl[6] && stall_cycles_q != 16'hFFFF) ? stall_cycles_q + 16'd1 : stall_cycles_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= RUN;
      cnt_q          <= 8'd0;
      stall_cycles_q <= 16'd0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end
  assign {pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_flush, md_busy} = ctl;
  assign stall_cycles = stall_cycles_q;
endmodule

// File: tb/tb_hazard_ctrl_206.sv
// tb_hazard_ctrl_206: directed self-checking bench for hazard_ctrl_206 (MD_CYCLES=4).
module tb_hazard_ctrl_206;
  localparam logic [6:0] C_NONE = 7'b0000000;
  localparam logic [6:0] C_HOLD = 7'b1101010;
  localparam logic [6:0] C_BR   = 7'b0010100;
  localparam logic [6:0] C_LU   = 7'b1100100;
  localparam logic [6:0] C_MD   = 7'b1101011;
  logic clk = 1'b0;
  logic rst_n;
  logic [4:0] rs_ID, rt_ID, rd_EX;
  logic uses_rt_ID, memread_EX, branch_taken_EX, md_start_EX, mem_req_MEM, mem_ready;
  logic pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_flush, md_busy;
  logic [15:0] stall_cycles;
  logic [6:0] outs;
  int total = 0;
  int passed = 0;
  always #5 clk = ~clk;
  hazard_ctrl_206 #(.MD_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .rs_ID(rs_ID), .rt_ID(rt_ID), .uses_rt_ID(uses_rt_ID),
    .rd_EX(rd_EX), .memread_EX(memread_EX), .branch_taken_EX(branch_taken_EX),
    .md_start_EX(md_start_EX), .mem_req_MEM(mem_req_MEM), .mem_ready(mem_ready),
    .pc_stall(pc_stall), .if_id_stall(if_id_stall), .if_id_flush(if_id_flush),
    .id_ex_stall(id_ex_stall), .id_ex_flush(id_ex_flush), .ex_mem_flush(ex_mem_flush),
    .md_busy(md_busy), .stall_cycles(stall_cycles)
  );
  assign outs = {pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_flush, md_busy};
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask
  // called at posedge+1: check combinational controls mid-cycle, then advance
  task automatic step(input string tag, input logic [6:0] e);
    #2;
    chk(tag, {9'd0, outs}, {9'd0, e});
    @(posedge clk);
    #1;
  endtask
  initial begin
    rst_n = 1'b0;
    rs_ID = 5'd5; rt_ID = 5'd0; rd_EX = 5'd5; uses_rt_ID = 1'b0;
    memread_EX = 1'b1; branch_taken_EX = 1'b1; md_start_EX = 1'b1;
    mem_req_MEM = 1'b1; mem_ready = 1'b0;
    #3;
    chk("rst_outs", {9'd0, outs}, 16'd0);
    chk("rst_sc", stall_cycles, 16'd0);
    @(posedge clk); #1;
    step("rst_hold", C_NONE);
    chk("rst_sc2", stall_cycles, 16'd0);
    memread_EX = 1'b0; branch_taken_EX = 1'b0; md_start_EX = 1'b0;
    mem_req_MEM = 1'b0; mem_ready = 1'b1;
    rst_n = 1'b1;
    step("idle", C_NONE);
    memread_EX = 1'b1; rd_EX = 5'd5; rs_ID = 5'd5;
    step("lu_rs", C_LU);
    memread_EX = 1'b0;
    step("lu_after", C_NONE);
    chk("lu_sc", stall_cycles, 16'd1);
    memread_EX = 1'b1; rd_EX = 5'd7; rt_ID = 5'd7; rs_ID = 5'd1; uses_rt_ID = 1'b0;
    step("lu_rt_unused", C_NONE);
    uses_rt_ID = 1'b1;
    step("lu_rt", C_LU);
    chk("lu_rt_sc", stall_cycles, 16'd2);
    rd_EX = 5'd0; rs_ID = 5'd0; rt_ID = 5'd0;
    step("lu_r0", C_NONE);
    rd_EX = 5'd5; rs_ID = 5'd5; uses_rt_ID = 1'b0; branch_taken_EX = 1'b1;
    step("br_lu", C_BR);
    chk("br_sc", stall_cycles, 16'd2);
    branch_taken_EX = 1'b0; memread_EX = 1'b0;
    mem_req_MEM = 1'b1; mem_ready = 1'b0;
    step("mw1", C_HOLD);
    step("mw2", C_HOLD);
    branch_taken_EX = 1'b1;
    step("mw3_br_held", C_HOLD);
    mem_ready = 1'b1;
    step("mw_exit", C_NONE);
    chk("mw_sc", stall_cycles, 16'd5);
    mem_req_MEM = 1'b0;
    step("br_after_mw", C_BR);
    branch_taken_EX = 1'b0;
    md_start_EX = 1'b1;
    step("md1", C_HOLD);
    branch_taken_EX = 1'b1; mem_req_MEM = 1'b1; mem_ready = 1'b0;
    step("md2", C_MD);
    step("md3", C_MD);
    step("md4_exit", C_NONE);
    md_start_EX = 1'b0; branch_taken_EX = 1'b0; mem_req_MEM = 1'b0; mem_ready = 1'b1;
    step("md_done", C_NONE);
    chk("md_sc", stall_cycles, 16'd8);
    md_start_EX = 1'b1;
    step("rm1", C_HOLD);
    chk("rm_sc_pre", stall_cycles, 16'd9);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rm_outs", {9'd0, outs}, 16'd0);
    chk("rm_sc", stall_cycles, 16'd0);
    md_start_EX = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    step("rm_after", C_NONE);
    step("rm_after2", C_NONE);
    chk("rm_sc_after", stall_cycles, 16'd0);
    mem_req_MEM = 1'b1; mem_ready = 1'b0;
    repeat (70000) @(posedge clk);
    #3;
    chk("sat_outs", {9'd0, outs}, {9'd0, C_HOLD});
    chk("sat_sc", stall_cycles, 16'hFFFF);
    @(posedge clk); #1;
    mem_ready = 1'b1;
    step("sat_exit", C_NONE);
    mem_req_MEM = 1'b0;
    memread_EX = 1'b1; rd_EX = 5'd0; rs_ID = 5'd0;
    step("sat_r0", C_NONE);
    chk("sat_sc_end", stall_cycles, 16'hFFFF);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
